piso_serializer: RTL and testbench

- Parallel-in/serial-out stage that sits directly upstream of the 4-bit sipo.
- Takes a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on serial_a, with shift_a asserted, so the sipo reassembles it.
- A one-entry holding register lets the next word queue while the current one shifts, so back-to-back words stream with shift_a held high continuously.

---
 rtl/piso_serializer.sv | 89 ++++++++
 tb/tb_piso_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the 4-bit sipo, with a one-entry holding register.
// Define PISO_MSB_FIRST_EN to shift MSB first; the default build shifts LSB first.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_a,
  output logic             shift_a,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] pend_data_q;
  logic             pend_valid_q;

  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;
  logic             head_bit;

`ifdef PISO_MSB_FIRST_EN
  assign shreg_shifted = shreg_q << 1;
  assign head_bit      = shreg_q[WIDTH-1];
`else
  assign shreg_shifted = shreg_q >> 1;
  assign head_bit      = shreg_q[0];
`endif

  // No combinational ready path: a drained slot shows up one cycle later.
  assign in_ready  = !pend_valid_q;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == StShift);
  assign shift_a   = busy;
  assign serial_a  = busy && head_bit;
  assign word_done = busy && (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q <= in_data;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cnt_q != LastCnt) begin
            shreg_q <= shreg_shifted;
            cnt_q   <= cnt_q + CntW'(1);
            if (accept) begin
              pend_data_q  <= in_data;
              pend_valid_q <= 1'b1;
            end
          end else if (pend_valid_q) begin
            // Queued word follows with no bubble on shift_a.
            shreg_q      <= pend_data_q;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
          end else if (accept) begin
            shreg_q <= in_data;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a scoreboard of expected serial bits and
// word_done flags is filled at each accept and drained whenever shift_a is seen high.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         serial_a;
  logic         shift_a;
  logic         word_done;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [1:0] sb[$];  // {serial bit, word_done}

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .serial_a  (serial_a),
    .shift_a   (shift_a),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (shift_a === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected_shift: shift_a=1 with no expected bit at %0t", $time);
        end else begin
          logic [1:0] exp;
          exp = sb.pop_front();
          if ({serial_a, word_done} !== exp) begin
            errors++;
            $display("FAIL mon_bit: serial_a,word_done=%b%b expected %b at %0t",
                     serial_a, word_done, exp, $time);
          end
        end
      end else begin
        checks++;
        if (serial_a !== 1'b0 || word_done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mon_idle: serial_a=%b word_done=%b busy=%b expected 0 at %0t",
                   serial_a, word_done, busy, $time);
        end
      end
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    logic b;
    for (int i = 0; i < W; i++) begin
`ifdef PISO_MSB_FIRST_EN
      b = d[W-1-i];
`else
      b = d[i];
`endif
      sb.push_back({b, (i == W - 1)});
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 4 * W + 4 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk);
      if (ok) push_word(d);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within bound for word %b", in_ready, d);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || shift_a !== 1'b0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || shift_a !== 1'b0) begin
      errors++;
      $display("FAIL drain: %0d bits still expected, shift_a=%b, expected 0 and 0",
               sb.size(), shift_a);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check_bit("rst_shift_a", shift_a, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_word_done", word_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_bit("idle_shift_a", shift_a, 1'b0);
      check_bit("idle_serial_a", serial_a, 1'b0);
      check_bit("idle_in_ready", in_ready, 1'b1);
      check_bit("idle_busy", busy, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    send(4'b1011);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("single_shift_a", shift_a, 1'b1);
      check_bit("single_word_done", word_done, k == 4);
    end
    @(negedge clk);
    check_bit("single_shift_drop", shift_a, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    send(4'b0110);
    send(4'b1001);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      check_bit("b2b_shift_a", shift_a, 1'b1);
      check_bit("b2b_in_ready", in_ready, k > 4);
      check_bit("b2b_word_done", word_done, k == 4 || k == 8);
    end
    @(negedge clk);
    check_bit("b2b_shift_drop", shift_a, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_direct_load();
    send(4'b1111);
    for (int k = 1; k <= 3; k++) begin
      check_bit("direct_ready_pre", in_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    check_bit("direct_last_bit", word_done, 1'b1);
    send(4'b0001);
    check_bit("direct_ready_post", in_ready, 1'b1);
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      check_bit("direct_shift_a", shift_a, 1'b1);
      check_bit("direct_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    check_bit("direct_shift_drop", shift_a, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_word();
    send(4'b1010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_shift_a", shift_a, 1'b0);
    check_bit("midrst_serial_a", serial_a, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_bit("midrst_after_shift", shift_a, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 24; i++) send(W'($urandom_range(0, (1 << W) - 1)));
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_direct_load();
    test_reset_mid_word();
    test_stream();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
